// File: rtl/ewb_drain.sv
// ewb_drain: pops the oldest dirty line from the L2 eviction write buffer and bursts it to memory.
// Latency: pop edge -> mem_write_o next cycle; per line 1 + beats + 1 cycles minimum (DONE gap).
// Backpressure: each beat holds until mem_resp_i; L2 reads win over starting a drain unless EWB is full.
//
// Ports: clk/rst (sync, active-high); EWB side ewb_empty_i/ewb_full_i/ewb_data_i/ewb_addr_i/ewb_yumi_o;
//        L2 arbitration rd_req_i/busy_o; memory burst mem_write_o/mem_addr_o/mem_burst_o/mem_resp_i;
//        forwarding fwd_check_i/fwd_tag_i/fwd_hit_o/fwd_data_o; perf drain_count_o/stall_count_o.
// Optional: define EWB_DRAIN_PERF_EN to build the perf counters; otherwise both perf ports read 0.
`timescale 1ns/1ps
module ewb_drain #(
   parameter int width = 256,
   parameter int beat  = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ewb_empty_i,
   input  logic             ewb_full_i,
   input  logic [width-1:0] ewb_data_i,
   input  logic [31:0]      ewb_addr_i,
   output logic             ewb_yumi_o,
   input  logic             rd_req_i,
   output logic             busy_o,
   output logic             mem_write_o,
   output logic [31:0]      mem_addr_o,
   output logic [beat-1:0]  mem_burst_o,
   input  logic             mem_resp_i,
   input  logic             fwd_check_i,
   input  logic [26:0]      fwd_tag_i,
   output logic             fwd_hit_o,
   output logic [width-1:0] fwd_data_o,
   output logic [31:0]      drain_count_o,
   output logic [31:0]      stall_count_o
);

   localparam int NBEATS = width / beat;
   localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [width-1:0] line_q, line_d;
   logic [31:0]      addr_q, addr_d;
   logic             start;

   // Reads win over starting a drain, except a full EWB forces the drain.
   assign start = !ewb_empty_i && (!rd_req_i || ewb_full_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      line_d      = line_q;
      addr_d      = addr_q;
      ewb_yumi_o  = 1'b0;
      mem_write_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               ewb_yumi_o = 1'b1;
               line_d     = ewb_data_i;
               addr_d     = ewb_addr_i;
               cnt_d      = '0;
               state_d    = WRITE;
            end
         end
         WRITE: begin
            // Bursts are never aborted by rd_req_i or ewb_full_i.
            mem_write_o = 1'b1;
            if (mem_resp_i) begin
               if (cnt_q == LAST_BEAT) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            // One idle cycle on mem_write_o separates back-to-back bursts.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q != IDLE) || ewb_yumi_o;

   // Address/data are only meaningful in WRITE; zero elsewhere keeps idle outputs quiet.
   assign mem_addr_o  = (state_q == WRITE) ? {addr_q[31:5], 5'b0} : 32'd0;
   assign mem_burst_o = (state_q == WRITE) ? line_q[int'(cnt_q)*beat +: beat] : '0;

   // Line offset bits never leave the block: the burst is always line-aligned.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^addr_q[4:0];

   // The pop cycle needs no coverage here: the entry is still visible to the EWB's own lookup.
   assign fwd_hit_o  = fwd_check_i && (state_q == WRITE) && (addr_q[31:5] == fwd_tag_i);
   assign fwd_data_o = fwd_hit_o ? line_q : '0;

`ifdef EWB_DRAIN_PERF_EN
   logic [31:0] drain_cnt_q, drain_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      drain_cnt_d = drain_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (state_q == DONE) begin
         drain_cnt_d = drain_cnt_q + 32'd1;
      end
      // A stall is a cycle where a drain was possible but a read took the port.
      if ((state_q == IDLE) && !ewb_empty_i && rd_req_i && !ewb_full_i) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drain_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         drain_cnt_q <= drain_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign drain_count_o = drain_cnt_q;
   assign stall_count_o = stall_cnt_q;
`else
   assign drain_count_o = 32'd0;
   assign stall_count_o = 32'd0;
`endif

endmodule
